regfile_write_demux: RTL

- Write side of the 32x32 register file: demultiplexes one write-back word to one of NUM_REGS registers selected by a 5-bit register address.
- Owns the register storage and drives all register contents as a flat bus into the existing 32-way read multiplexers.
- One-stage write staging pipeline (accept, then commit) plus commit status and counter outputs for the multicycle control unit and the bench.

---
 rtl/regfile_write_demux_if.sv | 38 +++
 rtl/regfile_write_demux.sv | 105 ++++++++++
 2 files changed

// File: rtl/regfile_write_demux_if.sv
// Write-side bus of the register file: request, flat contents, status.
// master drives RegWrite/WriteRegister/WriteData; slave drives the rest.
interface regfile_write_demux_if #(
  parameter int NUM_REGS = 32,
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5
);
  logic                       RegWrite;
  logic [ADDR_W-1:0]          WriteRegister;
  logic [DATA_W-1:0]          WriteData;
  logic [NUM_REGS*DATA_W-1:0] RegOut;
  logic                       PendingValid;
  logic [ADDR_W-1:0]          PendingReg;
  logic                       WriteDone;
  logic [15:0]                WriteCount;

  modport master (
    output RegWrite,
    output WriteRegister,
    output WriteData,
    input  RegOut,
    input  PendingValid,
    input  PendingReg,
    input  WriteDone,
    input  WriteCount
  );

  modport slave (
    input  RegWrite,
    input  WriteRegister,
    input  WriteData,
    output RegOut,
    output PendingValid,
    output PendingReg,
    output WriteDone,
    output WriteCount
  );
endinterface

// File: rtl/regfile_write_demux.sv
// Register file write side: stage a write, commit it next edge via a
// one-hot decode, expose flat contents plus commit status and count.
// Ports: clk, rst_n (async active-low), bus (regfile_write_demux_if.slave).
// Option: REGFILE_WRITE_FORWARD_EN forwards the staged word onto RegOut.
module regfile_write_demux #(
  parameter int NUM_REGS = 32,
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5
) (
  input logic                  clk,
  input logic                  rst_n,
  regfile_write_demux_if.slave bus
);

  logic              r_pend_valid;
  logic [ADDR_W-1:0] r_pend_reg;
  logic [DATA_W-1:0] r_pend_data;
  logic              r_done;
  logic [15:0]       r_count;

  logic                       w_commit;
  logic                       w_inc;
  logic [NUM_REGS-1:0]        w_sel;
  logic [DATA_W-1:0]          w_q [NUM_REGS];
  logic [NUM_REGS*DATA_W-1:0] w_regout;

  assign w_commit = r_pend_valid;

  always_comb begin
    w_sel = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      w_sel[i] = w_commit &&
                 (r_pend_reg == ADDR_W'(i));
    end
  end

  // A commit aimed at register 0 is still a commit,
  // but it is not counted.
  assign w_inc = w_commit && !w_sel[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_valid <= 1'b0;
      r_pend_reg   <= '0;
      r_pend_data  <= '0;
    end else begin
      r_pend_valid <= bus.RegWrite;
      if (bus.RegWrite) begin
        r_pend_reg  <= bus.WriteRegister;
        r_pend_data <= bus.WriteData;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done  <= 1'b0;
      r_count <= '0;
    end else begin
      r_done <= w_commit;
      if (w_inc) begin
        r_count <= r_count + 16'd1;
      end
    end
  end

  genvar n;
  generate
    for (n = 0; n < NUM_REGS; n++) begin : g_reg
      if (n == 0) begin : g_zero
        assign w_q[n] = '0;
      end else begin : g_store
        logic [DATA_W-1:0] r_q;
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            r_q <= '0;
          end else if (w_sel[n]) begin
            r_q <= r_pend_data;
          end
        end
        assign w_q[n] = r_q;
      end
    end
  endgenerate

  always_comb begin
    w_regout = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      w_regout[i*DATA_W +: DATA_W] = w_q[i];
`ifdef REGFILE_WRITE_FORWARD_EN
      // Staged word is visible before it lands in storage.
      if (i != 0 && w_sel[i]) begin
        w_regout[i*DATA_W +: DATA_W] = r_pend_data;
      end
`endif
    end
  end

  assign bus.RegOut       = w_regout;
  assign bus.PendingValid = r_pend_valid;
  assign bus.PendingReg   = r_pend_reg;
  assign bus.WriteDone    = r_done;
  assign bus.WriteCount   = r_count;

endmodule
